loader_mem_writer: RTL and testbench
====================================

LOADER_MEM_WRITER -- requirements
Module: loader_mem_writer

Interface
REQ-001 Parameter ADDRESS_SIZE, default 28, byte-address width of the incoming loader write stream.
REQ-002 Parameter FIFO_DEPTH, default 4, number of packed-word entries queued toward memory; power of two, at least 2.
REQ-003 Parameter FLUSH_TIMEOUT, default 15, idle cycles after which a partial staged word is pushed; range 1..255.
REQ-004 clk_memory  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_write_en  input  1  one-cycle strobe: byte write from the upstream loader.
REQ-007 in_write_addr  input  ADDRESS_SIZE  byte address of in_write_data.
REQ-008 in_write_data  input  8  byte to write.
REQ-009 flush  input  1  one-cycle strobe: push any partial staged word immediately.
REQ-010 mem_req  output  1  a word write is presented to the memory controller.
REQ-011 mem_ack  input  1  memory controller accepts the presented word this cycle.
REQ-012 mem_addr  output  ADDRESS_SIZE-1  16-bit word address (in_write_addr[ADDRESS_SIZE-1:1]).
REQ-013 mem_data  output  16  packed word; the even-address byte occupies bits [7:0].
REQ-014 mem_be  output  2  byte enables; bit 0 for [7:0], bit 1 for [15:8].
REQ-015 busy  output  1  staging valid OR FIFO non-empty OR mem_req high.
REQ-016 overflow  output  1  sticky: a packed word was dropped because the FIFO was full.

Function
REQ-017 One staging register SHALL hold {word address, data, be, valid}; in_write_addr[0] selects the byte lane.
REQ-018 Byte to empty staging: load it with the word address, the byte in its lane, and the corresponding single be bit set.
REQ-019 Byte to valid staging with the same word address (combine enabled): merge the byte into its lane and OR its be bit; a repeated lane overwrites.
REQ-020 Byte to valid staging with a different word address: push the old staging and load the new byte in the same cycle.
REQ-021 Staging with be==2'b11 SHALL be pushed on the following cycle; the push and a new byte's load may coincide.
REQ-022 Idle counter: reset to 0 on any in_write_en; increment each cycle staging is valid without a write; push at FLUSH_TIMEOUT.
REQ-023 flush push takes effect that cycle; flush concurrent with a new byte pushes old staging, then loads the new byte.
REQ-024 Push into a full FIFO: drop the word, set overflow; a pop and a push in the same cycle on a full FIFO is not a drop.
REQ-025 Output FSM has two states: IDLE and REQ. IDLE->REQ when the FIFO is non-empty. In REQ, mem_req=1 with mem_addr/mem_data/mem_be held from the FIFO head.
REQ-026 mem_ack high in REQ pops the head; stay in REQ if another entry remains (back-to-back, no bubble), else go to IDLE.
REQ-027 mem_ack while mem_req is low SHALL be ignored.
REQ-028 Latency: byte completing a word -> FIFO entry at +1 cycle -> mem_req earliest at +2 cycles.
REQ-029 Output word order equals push order; no reordering.

Reset
REQ-030 Reset asserted: mem_req=0, mem_addr=0, mem_data=0, mem_be=0, busy=0, overflow=0, staging invalid, FIFO empty, idle counter 0, FSM IDLE, immediately (asynchronously).
REQ-031 Reset mid-handshake SHALL drop mem_req at once and discard all staged and queued data.

Configuration
REQ-032 Macro LOADER_WRITER_COMBINE_EN defined: byte merging per REQ-019/021 is active.
REQ-033 Macro not defined: every byte is pushed on the following cycle as its own word with a single be bit; the idle counter and its logic are omitted.

Structure
REQ-034 Package loader_writer_pkg SHALL hold typedef word_entry_t {addr, data[15:0], be[1:0]} and constant BE_FULL=2'b11.
REQ-035 Sub-module loader_write_fifo (synchronous FIFO of word_entry_t, depth FIFO_DEPTH, full/empty flags, same clock and reset) SHALL be instantiated once.

Verification
REQ-036 Bytes 0x11@0x100, 0x22@0x101 on consecutive cycles, mem_ack tied 1 -> one write: mem_addr=0x80, mem_data=0x2211, mem_be=2'b11.
REQ-037 Single byte 0xAB@0x203 then idle -> after 15 idle cycles, push: mem_addr=0x101, mem_data[15:8]=0xAB, mem_be=2'b10.
REQ-038 mem_ack held 0; 12 bytes at ascending addresses -> 4 words queued, the word in staging is kept, later completed words dropped; overflow=1, stays 1 until reset.
REQ-039 Byte 0x55@0x10 then flush in the same cycle as byte 0x66@0x40 -> two words, mem_be=2'b01 each, order 0x08 then 0x20.
REQ-040 Reset asserted while mem_req=1 with 2 queued entries -> mem_req=0 the same cycle, busy=0; no writes after deassertion.
REQ-041 Without LOADER_WRITER_COMBINE_EN, the stimulus of REQ-036 -> two writes at mem_addr=0x80 with mem_be=2'b01 then 2'b10.

Source files
------------

// File: rtl/loader_writer_pkg.sv
// loader_writer_pkg: shared types and constants for the loader memory writer.
//   word_entry_t : one packed word headed for memory {word addr, data, byte enables}
//   ENTRY_W      : flat width of word_entry_t, used on the FIFO ports
//   BE_FULL      : both byte lanes written
//   wr_state_t   : output handshake FSM states
package loader_writer_pkg;
    localparam int WORD_ADDR_W = 27;
    localparam logic [1:0] BE_FULL = 2'b11;
    typedef struct packed {
        logic [WORD_ADDR_W-1:0] addr;
        logic [15:0]            data;
        logic [1:0]             be;
    } word_entry_t;
    localparam int ENTRY_W = $bits(word_entry_t);
    typedef enum logic {ST_IDLE, ST_REQ} wr_state_t;
    // Single byte placed in its lane; the other lane reads as zero.
    function automatic word_entry_t lane_word(input logic [WORD_ADDR_W-1:0] addr, input logic hi, input logic [7:0] b);
        return '{addr: addr, data: hi ? {b, 8'h00} : {8'h00, b}, be: {hi, ~hi}};
    endfunction
endpackage

// File: rtl/loader_write_fifo.sv
// loader_write_fifo: synchronous FIFO of packed words queued toward memory.
//   clk_memory, reset : clock and asynchronous active-high reset
//   push, push_data   : enqueue request; accepted when not full or when popping
//   pop, head         : dequeue request and the current head entry
//   full, empty, count: occupancy flags and entry count
module loader_write_fifo
    import loader_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_memory,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    word_entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign wr    = push && (!full || pop);
    assign rd    = pop && !empty;
    assign head  = mem[rp];
    always_ff @(posedge clk_memory)
        if (wr) mem[wp] <= word_entry_t'(push_data);
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/loader_mem_writer.sv
// loader_mem_writer: packs loader byte writes into 16-bit words and hands them to memory.
//   clk_memory, reset          : clock and asynchronous active-high reset
//   in_write_en/addr/data      : byte write strobe from the loader
//   flush                      : push any partially staged word now
//   mem_req/ack, addr/data/be  : word write handshake toward the memory controller
//   busy, overflow             : activity flag and sticky dropped-word flag
//   LOADER_WRITER_COMBINE_EN   : when defined, bytes of one word merge in staging;
//                                otherwise every byte leaves as its own word
module loader_mem_writer
    import loader_writer_pkg::*;
#(
    parameter int ADDRESS_SIZE  = 28,
    parameter int FIFO_DEPTH    = 4,
    parameter int FLUSH_TIMEOUT = 15
) (
    input  logic                    clk_memory,
    input  logic                    reset,
    input  logic                    in_write_en,
    input  logic [ADDRESS_SIZE-1:0] in_write_addr,
    input  logic [7:0]              in_write_data,
    input  logic                    flush,
    output logic                    mem_req,
    input  logic                    mem_ack,
    output logic [ADDRESS_SIZE-2:0] mem_addr,
    output logic [15:0]             mem_data,
    output logic [1:0]              mem_be,
    output logic                    busy,
    output logic                    overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    word_entry_t stg, in_word, head;
    wr_state_t state, next_state;
    logic stg_valid, push, pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [ENTRY_W-1:0] head_raw;
    assign in_word = lane_word(WORD_ADDR_W'(in_write_addr[ADDRESS_SIZE-1:1]), in_write_addr[0], in_write_data);
`ifdef LOADER_WRITER_COMBINE_EN
    word_entry_t merged;
    logic [7:0] idle_cnt;
    logic same;
    assign same   = stg_valid && stg.addr == in_word.addr;
    assign merged = '{addr: stg.addr,
                      data: in_write_addr[0] ? {in_write_data, stg.data[7:0]} : {stg.data[15:8], in_write_data},
                      be:   stg.be | in_word.be};
    assign push   = stg_valid && (stg.be == BE_FULL || flush || idle_cnt == 8'(FLUSH_TIMEOUT) || (in_write_en && !same));
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            stg       <= '0;
            stg_valid <= 1'b0;
            idle_cnt  <= '0;
        end else if (in_write_en) begin
            stg       <= (same && !push) ? merged : in_word;
            stg_valid <= 1'b1;
            idle_cnt  <= '0;
        end else if (push) begin
            stg_valid <= 1'b0;
            idle_cnt  <= '0;
        end else if (stg_valid) begin
            idle_cnt  <= idle_cnt + 8'd1;
        end
    end
`else
    // Bytes never linger in staging, so flush and the timeout have nothing to force out.
    assign push = stg_valid | (flush & stg_valid & (FLUSH_TIMEOUT != 0));
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            stg       <= '0;
            stg_valid <= 1'b0;
        end else begin
            stg_valid <= in_write_en;
            if (in_write_en) stg <= in_word;
        end
    end
`endif
    loader_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_memory (clk_memory),
        .reset      (reset),
        .push       (push),
        .push_data  (stg),
        .pop        (pop),
        .head       (head_raw),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );
    assign head = word_entry_t'(head_raw);
    assign pop  = mem_req && mem_ack;
    always_ff @(posedge clk_memory or posedge reset)
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    // Leave REQ only when the acked head was the last entry and nothing arrives behind it.
    always_comb begin
        next_state = state;
        next_state = state == ST_IDLE ? (fifo_empty ? ST_IDLE : ST_REQ)
                   : (mem_ack && fifo_count <= CW'(1) && !push) ? ST_IDLE : ST_REQ;
    end
    always_ff @(posedge clk_memory or posedge reset)
        if (reset)                          overflow <= 1'b0;
        else if (push && fifo_full && !pop) overflow <= 1'b1;
    assign mem_req  = state == ST_REQ;
    assign mem_addr = mem_req ? (ADDRESS_SIZE-1)'(head.addr) : '0;
    assign mem_data = mem_req ? head.data : '0;
    assign mem_be   = mem_req ? head.be : '0;
    assign busy     = stg_valid || !fifo_empty || mem_req;
endmodule

// File: tb/tb_loader_mem_writer.sv
// tb_loader_mem_writer: directed and randomized checks of loader_mem_writer against a word-level model.
module tb_loader_mem_writer;
    localparam int AS = 28;
    logic clk_memory = 1'b0;
    logic reset, in_write_en, flush, mem_ack, mem_req, busy, overflow;
    logic [AS-1:0] in_write_addr;
    logic [7:0] in_write_data;
    logic [AS-2:0] mem_addr;
    logic [15:0] mem_data;
    logic [1:0] mem_be;
    int checks = 0, failures = 0;
    typedef struct {logic wr; logic [AS-1:0] addr; logic [7:0] data; logic fl;} cyc_t;
    cyc_t stim[$];
    logic [44:0] got[$], exp_q[$];

    always #5 clk_memory = ~clk_memory;

    loader_mem_writer dut (
        .clk_memory    (clk_memory),
        .reset         (reset),
        .in_write_en   (in_write_en),
        .in_write_addr (in_write_addr),
        .in_write_data (in_write_data),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_be        (mem_be),
        .busy          (busy),
        .overflow      (overflow)
    );

    // Inputs change 1 time unit after posedge, so at negedge they show what the next edge will see.
    always @(negedge clk_memory)
        if (!reset && mem_req && mem_ack) got.push_back({mem_addr, mem_data, mem_be});

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    function automatic logic [44:0] w(input logic [26:0] a, input logic [15:0] d, input logic [1:0] b);
        return {a, d, b};
    endfunction

    task automatic cyc(input logic wr, input logic [AS-1:0] a, input logic [7:0] d, input logic fl);
        in_write_en = wr; in_write_addr = a; in_write_data = d; flush = fl;
        stim.push_back('{wr, a, d, fl});
        @(posedge clk_memory); #1;
        in_write_en = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_memory); #1;
        @(posedge clk_memory); #1;
        reset = 1'b0;
        stim.delete(); got.delete(); exp_q.delete();
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!mem_req && n < 100) begin idle(1); n++; end
    endtask

    task automatic drain();
        int k = 0;
        while (busy && k < 500) begin idle(1); k++; end
        chk("drain_in_time", k < 500, 1);
    endtask

    task automatic cmp_words(input string tag);
        chk($sformatf("%s_count", tag), got.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got.size()) chk($sformatf("%s_word%0d", tag, i), got[i], exp_q[i]);
    endtask

    // Word stream the rules produce from the recorded per-cycle stimulus.
    task automatic model_run();
        logic sv = 1'b0;
        logic [26:0] sa = '0;
        logic [15:0] sd = '0;
        logic [1:0] sb = '0;
        int gap = 0;
        exp_q.delete();
        foreach (stim[i]) begin
`ifdef LOADER_WRITER_COMBINE_EN
            if (sv && (sb == 2'b11 || stim[i].fl || gap == 15 || (stim[i].wr && stim[i].addr[AS-1:1] != sa))) begin
                exp_q.push_back(w(sa, sd, sb));
                sv = 1'b0; gap = 0;
            end
            if (stim[i].wr) begin
                if (!sv) begin sa = stim[i].addr[AS-1:1]; sd = '0; sb = '0; end
                if (stim[i].addr[0]) begin sd[15:8] = stim[i].data; sb[1] = 1'b1; end
                else begin sd[7:0] = stim[i].data; sb[0] = 1'b1; end
                sv = 1'b1; gap = 0;
            end else if (sv) gap++;
`else
            if (stim[i].wr)
                exp_q.push_back(stim[i].addr[0] ? w(stim[i].addr[AS-1:1], {stim[i].data, 8'h00}, 2'b10)
                                                : w(stim[i].addr[AS-1:1], {8'h00, stim[i].data}, 2'b01));
`endif
        end
    endtask

    initial begin
        int n;
        logic [AS-1:0] base;
        reset = 1'b1; in_write_en = 1'b0; in_write_addr = '0; in_write_data = '0; flush = 1'b0; mem_ack = 1'b1;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);

        // Two bytes of one word, ack tied high
        do_reset();
        cyc(1'b1, 28'h100, 8'h11, 1'b0);
        cyc(1'b1, 28'h101, 8'h22, 1'b0);
        wait_req(n);
`ifdef LOADER_WRITER_COMBINE_EN
        chk("pair_latency", n, 2);
        exp_q = '{w(27'h80, 16'h2211, 2'b11)};
`else
        chk("pair_latency", n, 1);
        exp_q = '{w(27'h80, 16'h0011, 2'b01), w(27'h80, 16'h2200, 2'b10)};
`endif
        drain();
        cmp_words("pair");

        // Lone byte left to the idle timeout
        do_reset();
        cyc(1'b1, 28'h203, 8'hAB, 1'b0);
        wait_req(n);
`ifdef LOADER_WRITER_COMBINE_EN
        chk("timeout_latency", n, 17);
`else
        chk("timeout_latency", n, 2);
`endif
        exp_q = '{w(27'h101, 16'hAB00, 2'b10)};
        drain();
        cmp_words("timeout");

        // Flush in the same cycle as a byte to a new word
        do_reset();
        cyc(1'b1, 28'h10, 8'h55, 1'b0);
        cyc(1'b1, 28'h40, 8'h66, 1'b1);
        idle(30);
        drain();
        exp_q = '{w(27'h08, 16'h0055, 2'b01), w(27'h20, 16'h0066, 2'b01)};
        cmp_words("flush");

        // Stalled memory: FIFO fills, later words drop, overflow sticks
        do_reset();
        mem_ack = 1'b0;
        for (int i = 0; i < 12; i++) cyc(1'b1, AS'(28'h400 + i), 8'(8'hC0 + i), 1'b0);
        idle(2);
        chk("ovf_set", overflow, 1);
        chk("ovf_req_held", mem_req, 1);
        chk("ovf_head_addr", mem_addr, 27'h200);
        model_run();
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        mem_ack = 1'b1;
        idle(30);
        drain();
        cmp_words("ovf");
        chk("ovf_sticky", overflow, 1);

        // Reset in the middle of a handshake with queued words
        do_reset();
        chk("ovf_cleared", overflow, 0);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, AS'(28'h300 + i), 8'(8'h30 + i), 1'b0);
        idle(2);
        chk("mid_req_before", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("mid_req_dropped", mem_req, 0);
        chk("mid_busy", busy, 0);
        chk("mid_addr", mem_addr, 0);
        @(posedge clk_memory); #1;
        reset = 1'b0;
        mem_ack = 1'b1;
        got.delete();
        idle(25);
        chk("mid_no_writes", got.size(), 0);

        // Randomized traffic against the model; ack held high so the FIFO cannot overflow
        do_reset();
        base = AS'($urandom_range(0, 32'h0FFF_FF00));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) base = AS'($urandom_range(0, 32'h0FFF_FF00));
            if ($urandom_range(0, 19) == 0) idle($urandom_range(10, 24));
            else cyc($urandom_range(0, 2) != 0, AS'(base + AS'($urandom_range(0, 5))), 8'($urandom), $urandom_range(0, 11) == 0);
        end
        idle(40);
        drain();
        model_run();
        cmp_words("rand");
        chk("rand_overflow", overflow, 0);
        chk("rand_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
